// File: rtl/sprite_pkg.sv
// Shared constants for the sprite compositor: colour/id widths and default
// coordinate width and transparent key.
package sprite_pkg;
  localparam int COLOR_W = 12;
  localparam int OBJ_ID_W = 3;
  localparam int DEF_COORD_W = 10;
  localparam logic [COLOR_W-1:0] DEF_TRANSPARENT = 12'h000;
endpackage

// File: rtl/obj_hit_unit.sv
// Per-object range test and ROM address generation; purely combinational.
// The end-of-box sums carry one extra bit so boxes at the screen edge clip instead of wrapping.
module obj_hit_unit
  import sprite_pkg::*;
#(
  parameter int OBJ_DIM = 2,
  parameter int ADDR_W  = 1,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic               obj_en,
  output logic               hit,
  output logic [ADDR_W-1:0]  row,
  output logic [ADDR_W-1:0]  col
);
  logic [COORD_W:0] x_end_s;
  logic [COORD_W:0] y_end_s;
  logic             in_x_s;
  logic             in_y_s;

  assign x_end_s = {1'b0, obj_x} + (COORD_W+1)'(OBJ_DIM);
  assign y_end_s = {1'b0, obj_y} + (COORD_W+1)'(OBJ_DIM);
  assign in_x_s  = (pix_x >= obj_x) && ({1'b0, pix_x} < x_end_s);
  assign in_y_s  = (pix_y >= obj_y) && ({1'b0, pix_y} < y_end_s);
  assign hit     = obj_en && in_x_s && in_y_s;

  // Only the low bits of the offset address the ROM
  assign col = pix_x[ADDR_W-1:0] - obj_x[ADDR_W-1:0];
  assign row = pix_y[ADDR_W-1:0] - obj_y[ADDR_W-1:0];
endmodule

// File: rtl/sprite_compositor_ctrl.sv
// Object sprite compositor: double-buffered object positions, ROM addressing,
// one-cycle ROM latency alignment and fixed-priority transparent compositing.
module sprite_compositor_ctrl
  import sprite_pkg::*;
#(
  parameter int N_OBJ   = 4,
  parameter int OBJ_DIM = 2,
  parameter int ADDR_W  = 1,
  parameter int COORD_W = DEF_COORD_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = DEF_TRANSPARENT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_idx,
  input  logic [COORD_W-1:0]        cfg_x,
  input  logic [COORD_W-1:0]        cfg_y,
  input  logic                      cfg_en,
  output logic                      cfg_pending,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [COORD_W-1:0]        pix_x,
  input  logic [COORD_W-1:0]        pix_y,
  input  logic [COLOR_W-1:0]        bg_color,
  output logic [N_OBJ*ADDR_W-1:0]   rom_row,
  output logic [N_OBJ*ADDR_W-1:0]   rom_col,
  input  logic [N_OBJ*COLOR_W-1:0]  rom_data,
  output logic                      out_valid,
  output logic [COLOR_W-1:0]        out_color,
  output logic                      out_hit,
  output logic [OBJ_ID_W-1:0]       out_obj_id
);
  logic [COORD_W-1:0] sh_x_r  [N_OBJ];
  logic [COORD_W-1:0] sh_y_r  [N_OBJ];
  logic               sh_en_r [N_OBJ];
  logic [COORD_W-1:0] act_x_r [N_OBJ];
  logic [COORD_W-1:0] act_y_r [N_OBJ];
  logic               act_en_r[N_OBJ];
  logic               pending_r;

  logic               wr_ok_s;
  logic               commit_s;
  logic [N_OBJ-1:0]   hit_s;
  logic [N_OBJ-1:0]   hit1_r;
  logic               valid1_r;
  logic [COLOR_W-1:0] bg1_r;
  logic [N_OBJ-1:0]   opaque_s;
  logic [N_OBJ-1:0]   lowest_s;
  logic               win_s;
  logic [OBJ_ID_W-1:0] win_id_s;
  logic [COLOR_W-1:0] win_color_s;

  assign wr_ok_s     = cfg_we && ({1'b0, cfg_idx} < 4'(N_OBJ));
  assign commit_s    = frame_start && pending_r;
  assign cfg_pending = pending_r;

  // Shadow/active banks; a commit copies the shadow as it stood before this edge's write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N_OBJ; k++) begin
        sh_x_r[k]   <= {COORD_W{1'b0}};
        sh_y_r[k]   <= {COORD_W{1'b0}};
        sh_en_r[k]  <= 1'b0;
        act_x_r[k]  <= {COORD_W{1'b0}};
        act_y_r[k]  <= {COORD_W{1'b0}};
        act_en_r[k] <= 1'b0;
      end
      pending_r <= 1'b0;
    end else begin
      for (int k = 0; k < N_OBJ; k++) begin
        if (commit_s) begin
          act_x_r[k]  <= sh_x_r[k];
          act_y_r[k]  <= sh_y_r[k];
          act_en_r[k] <= sh_en_r[k];
        end
        if (wr_ok_s && (cfg_idx == 3'(k))) begin
          sh_x_r[k]  <= cfg_x;
          sh_y_r[k]  <= cfg_y;
          sh_en_r[k] <= cfg_en;
        end
      end
      if (wr_ok_s) begin
        pending_r <= 1'b1;
      end else if (frame_start) begin
        pending_r <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
    obj_hit_unit #(
      .OBJ_DIM (OBJ_DIM),
      .ADDR_W  (ADDR_W),
      .COORD_W (COORD_W)
    ) u_hit (
      .pix_x  (pix_x),
      .pix_y  (pix_y),
      .obj_x  (act_x_r[k]),
      .obj_y  (act_y_r[k]),
      .obj_en (act_en_r[k]),
      .hit    (hit_s[k]),
      .row    (rom_row[k*ADDR_W +: ADDR_W]),
      .col    (rom_col[k*ADDR_W +: ADDR_W])
    );
    assign opaque_s[k] = hit1_r[k] && (rom_data[k*COLOR_W +: COLOR_W] != TRANSPARENT);
  end

  // Stage 1 waits alongside the ROM read; hits are masked for invalid pixels
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit1_r   <= {N_OBJ{1'b0}};
      valid1_r <= 1'b0;
      bg1_r    <= {COLOR_W{1'b0}};
    end else begin
      hit1_r   <= pix_valid ? hit_s : {N_OBJ{1'b0}};
      valid1_r <= pix_valid;
      bg1_r    <= bg_color;
    end
  end

  // Isolate the lowest opaque object, then OR-reduce its index and colour
  assign lowest_s = opaque_s & (~opaque_s + N_OBJ'(1));
  assign win_s    = |opaque_s;

  // Priority mux built from the one-hot winner
  always_comb begin
    win_id_s    = {OBJ_ID_W{1'b0}};
    win_color_s = {COLOR_W{1'b0}};
    for (int k = 0; k < N_OBJ; k++) begin
      win_id_s    = win_id_s | (lowest_s[k] ? OBJ_ID_W'(k) : {OBJ_ID_W{1'b0}});
      win_color_s = win_color_s | ({COLOR_W{lowest_s[k]}} & rom_data[k*COLOR_W +: COLOR_W]);
    end
  end

  // Registered composite output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_color  <= {COLOR_W{1'b0}};
      out_hit    <= 1'b0;
      out_obj_id <= {OBJ_ID_W{1'b0}};
    end else if (valid1_r) begin
      out_valid  <= 1'b1;
      out_color  <= win_s ? win_color_s : bg1_r;
      out_hit    <= win_s;
      out_obj_id <= win_id_s;
    end else begin
      out_valid  <= 1'b0;
      out_color  <= {COLOR_W{1'b0}};
      out_hit    <= 1'b0;
      out_obj_id <= {OBJ_ID_W{1'b0}};
    end
  end
endmodule

// File: tb/tb_sprite_compositor_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of banks, hit test, priority and 2-cycle latency.
module tb_sprite_compositor_ctrl;
  localparam int N_OBJ = 4;
  localparam int OBJ_DIM = 2;
  localparam int ADDR_W = 1;
  localparam int COORD_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_n = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [2:0]               cfg_idx = 3'd0;
  logic [COORD_W-1:0]       cfg_x = 10'd0, cfg_y = 10'd0;
  logic                     cfg_en = 1'b0;
  logic                     cfg_pending;
  logic                     frame_start = 1'b0;
  logic                     pix_valid = 1'b0;
  logic [COORD_W-1:0]       pix_x = 10'd0, pix_y = 10'd0;
  logic [11:0]              bg_color = 12'h000;
  logic [N_OBJ*ADDR_W-1:0]  rom_row, rom_col;
  logic [N_OBJ*12-1:0]      rom_data = '0;
  logic                     out_valid;
  logic [11:0]              out_color;
  logic                     out_hit;
  logic [2:0]               out_obj_id;

  sprite_compositor_ctrl #(.N_OBJ(N_OBJ), .OBJ_DIM(OBJ_DIM), .ADDR_W(ADDR_W), .COORD_W(COORD_W),
                           .TRANSPARENT(12'h000)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_en(cfg_en), .cfg_pending(cfg_pending), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .bg_color(bg_color),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data), .out_valid(out_valid),
    .out_color(out_color), .out_hit(out_hit), .out_obj_id(out_obj_id)
  );

  // Sprite ROMs with one-cycle registered read
  logic [11:0] mem [N_OBJ][OBJ_DIM][OBJ_DIM];
  always @(posedge clk)
    for (int k = 0; k < N_OBJ; k++)
      rom_data[k*12 +: 12] <= mem[k][rom_row[k*ADDR_W +: ADDR_W]][rom_col[k*ADDR_W +: ADDR_W]];

  typedef struct { bit v; logic [11:0] c; bit h; int id; } res_t;

  int  sh_x[N_OBJ], sh_y[N_OBJ], act_x[N_OBJ], act_y[N_OBJ];
  bit  sh_en[N_OBJ], act_en[N_OBJ];
  bit  m_pend;
  res_t p1, exp_o;
  bit  ae_hit[N_OBJ];
  int  ae_row[N_OBJ], ae_col[N_OBJ];
  bit  chk_on = 1'b0;
  int  n_checks = 0, n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic bit inside_obj(int k, int px, int py);
    return act_en[k] && px >= act_x[k] && px < act_x[k] + OBJ_DIM &&
           py >= act_y[k] && py < act_y[k] + OBJ_DIM;
  endfunction

  function automatic res_t eval_pix(int px, int py, bit pv, logic [11:0] bg);
    res_t r;
    logic [11:0] c;
    r = '{v: 1'b0, c: 12'h000, h: 1'b0, id: 0};
    if (pv) begin
      r.v = 1'b1;
      r.c = bg;
      for (int k = 0; k < N_OBJ; k++) begin
        if (!r.h && inside_obj(k, px, py)) begin
          c = mem[k][py - act_y[k]][px - act_x[k]];
          if (c != 12'h000) begin
            r.h = 1'b1; r.c = c; r.id = k;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic upd_addr();
    for (int k = 0; k < N_OBJ; k++) begin
      ae_hit[k] = inside_obj(k, int'(pix_x), int'(pix_y));
      ae_row[k] = (int'(pix_y) - act_y[k]) & (OBJ_DIM - 1);
      ae_col[k] = (int'(pix_x) - act_x[k]) & (OBJ_DIM - 1);
    end
  endtask

  // One clock: model advances after the negedge compare, returns #1 past the posedge
  task automatic tick();
    res_t n;
    upd_addr();
    @(negedge clk); #1;
    n = eval_pix(int'(pix_x), int'(pix_y), pix_valid, bg_color);
    if (!reset_n) begin
      for (int k = 0; k < N_OBJ; k++) begin
        sh_x[k] = 0; sh_y[k] = 0; sh_en[k] = 0; act_x[k] = 0; act_y[k] = 0; act_en[k] = 0;
      end
      m_pend = 0;
      p1 = '{v: 1'b0, c: 12'h000, h: 1'b0, id: 0};
      exp_o = p1;
    end else begin
      exp_o = p1;
      p1 = n;
      if (frame_start && m_pend)
        for (int k = 0; k < N_OBJ; k++) begin
          act_x[k] = sh_x[k]; act_y[k] = sh_y[k]; act_en[k] = sh_en[k];
        end
      if (cfg_we && int'(cfg_idx) < N_OBJ) begin
        sh_x[cfg_idx] = int'(cfg_x); sh_y[cfg_idx] = int'(cfg_y); sh_en[cfg_idx] = cfg_en;
        m_pend = 1;
      end else if (frame_start) begin
        m_pend = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", 32'(out_valid), 32'(exp_o.v));
      chk("out_color", 32'(out_color), 32'(exp_o.c));
      chk("out_hit", 32'(out_hit), 32'(exp_o.h));
      chk("out_obj_id", 32'(out_obj_id), 32'(exp_o.id));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
      for (int k = 0; k < N_OBJ; k++)
        if (ae_hit[k]) begin
          chk("rom_row", 32'(rom_row[k*ADDR_W +: ADDR_W]), 32'(ae_row[k]));
          chk("rom_col", 32'(rom_col[k*ADDR_W +: ADDR_W]), 32'(ae_col[k]));
        end
    end
  end

  task automatic wr(int idx, int x, int y, bit en);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_x = 10'(x); cfg_y = 10'(y); cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic px_set(int x, int y);
    pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
    #1;
  endtask

  task automatic px_done();
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic px(int x, int y);
    px_set(x, y);
    px_done();
  endtask

  function automatic logic [9:0] rnd_coord();
    if ($urandom_range(0, 9) == 0) return 10'(1023 - $urandom_range(0, 2));
    return 10'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int k = 0; k < N_OBJ; k++)
      for (int r = 0; r < OBJ_DIM; r++)
        for (int c = 0; c < OBJ_DIM; c++) mem[k][r][c] = 12'h000;
    reset_n = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    reset_n = 1'b1;
    tick();

    // Background only, 2-cycle latency
    bg_color = 12'h0F0;
    px_set(5, 5);
    tick();
    chk("lat1_valid", 32'(out_valid), 32'd0);
    pix_valid = 1'b0;
    tick();
    chk("bg_valid", 32'(out_valid), 32'd1);
    chk("bg_color", 32'(out_color), 32'h0F0);
    chk("bg_hit", 32'(out_hit), 32'd0);

    // Single object with addresses
    wr(1, 100, 50, 1'b1);
    fs();
    mem[1][1][1] = 12'hFFF;
    px_set(101, 51);
    chk("addr_row1", 32'(rom_row[1]), 32'd1);
    chk("addr_col1", 32'(rom_col[1]), 32'd1);
    px_done();
    chk("obj1_color", 32'(out_color), 32'hFFF);
    chk("obj1_id", 32'(out_obj_id), 32'd1);
    chk("obj1_hit", 32'(out_hit), 32'd1);

    // Overlap: transparent fall-through, then priority
    wr(1, 100, 50, 1'b0);
    wr(0, 100, 50, 1'b1);
    wr(2, 100, 50, 1'b1);
    fs();
    mem[2][1][1] = 12'hABC;
    px(101, 51);
    chk("fall_color", 32'(out_color), 32'hABC);
    chk("fall_id", 32'(out_obj_id), 32'd2);
    mem[0][1][1] = 12'h123;
    px(101, 51);
    chk("prio_color", 32'(out_color), 32'h123);
    chk("prio_id", 32'(out_obj_id), 32'd0);

    // Mid-frame write stays in shadow until frame_start
    wr(0, 200, 200, 1'b1);
    chk("pend_set", 32'(cfg_pending), 32'd1);
    px(101, 51);
    chk("shadow_id", 32'(out_obj_id), 32'd0);
    fs();
    chk("pend_clr", 32'(cfg_pending), 32'd0);
    px(101, 51);
    chk("commit_id", 32'(out_obj_id), 32'd2);

    // Simultaneous write and frame_start commits the old value
    wr(3, 10, 10, 1'b1);
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_x = 10'd300; cfg_y = 10'd300; cfg_en = 1'b1;
    frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    chk("simul_pend", 32'(cfg_pending), 32'd1);
    px(101, 51);
    chk("simul_old_id", 32'(out_obj_id), 32'd2);
    fs();
    px(101, 51);
    chk("simul_new_hit", 32'(out_hit), 32'd0);
    chk("simul_new_col", 32'(out_color), 32'h0F0);

    // Right-edge clipping, then reset mid-stream
    wr(0, 1023, 0, 1'b1);
    fs();
    mem[0][0][0] = 12'h777;
    px(0, 0);
    chk("nowrap_hit", 32'(out_hit), 32'd0);
    px(1023, 0);
    chk("edge_color", 32'(out_color), 32'h777);
    chk("edge_hit", 32'(out_hit), 32'd1);
    px_set(1023, 0);
    tick();
    reset_n = 1'b0;
    tick();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    pix_valid = 1'b0;
    tick();
    px(1023, 0);
    chk("rst_dis_hit", 32'(out_hit), 32'd0);
    chk("rst_dis_valid", 32'(out_valid), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      cfg_we      = ($urandom_range(0, 5) == 0);
      cfg_idx     = 3'($urandom_range(0, 7));
      cfg_x       = rnd_coord();
      cfg_y       = rnd_coord();
      cfg_en      = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 9) == 0);
      pix_valid   = ($urandom_range(0, 4) != 0);
      pix_x       = rnd_coord();
      pix_y       = rnd_coord();
      bg_color    = 12'($urandom);
      if ($urandom_range(0, 3) == 0)
        mem[$urandom_range(0, N_OBJ-1)][$urandom_range(0, 1)][$urandom_range(0, 1)] =
          ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
      tick();
    end
    reset_n = 1'b1; cfg_we = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
